// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: datapath widths and the register-dump FSM state type.
package mips32_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      SEND,
      DONE
   } regdump_state_t;

endpackage

// File: rtl/mips32_reg_dump.sv
// Post-halt register-file readout: walks R0..R(REG_COUNT-1) through a one-cycle
// read port and streams each value out on a valid/ready channel tagged with its index.
module mips32_reg_dump
   import mips32_pkg::*;
#(
   parameter int REG_COUNT = 8
) (
   input  logic                  clk1,
   input  logic                  rst_n,
   input  logic                  halted,
   input  logic                  trig,
   output logic                  rf_rd_en,
   output logic [REG_ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0]     rf_data,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [DATA_W-1:0]     dump_data,
   output logic [REG_ADDR_W-1:0] dump_idx,
   output logic                  dump_last,
   output logic                  done
);

   localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(REG_COUNT - 1);

   regdump_state_t        state_q;
   logic [REG_ADDR_W-1:0] idx_q;
   logic                  halted_q;
   logic                  primed_q;
   logic                  rf_rd_en_q;
   logic [REG_ADDR_W-1:0] rf_addr_q;
   logic                  dump_valid_q;
   logic [DATA_W-1:0]     dump_data_q;
   logic [REG_ADDR_W-1:0] dump_idx_q;
   logic                  dump_last_q;
   logic                  done_q;
   logic                  start_d;

   // primed_q masks the first cycle after reset so a core that is already halted
   // does not look like a fresh halted edge; only trig can restart it then.
   assign start_d = primed_q & halted & (~halted_q | trig);

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // register samples the pre-edge values; blocking here would chain within one edge.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         halted_q     <= 1'b0;
         primed_q     <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         rf_addr_q    <= '0;
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
         dump_idx_q   <= '0;
         dump_last_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         halted_q   <= halted;
         primed_q   <= 1'b1;
         rf_rd_en_q <= 1'b0;
         rf_addr_q  <= '0;

         case (state_q)
            IDLE: begin
               if (start_d) begin
                  idx_q      <= '0;
                  rf_rd_en_q <= 1'b1;
                  rf_addr_q  <= '0;
                  state_q    <= RD;
               end
            end

            RD: state_q <= CAP;

            CAP: begin
               dump_data_q  <= rf_data;
               dump_idx_q   <= idx_q;
               dump_last_q  <= (idx_q == LAST_IDX);
               dump_valid_q <= 1'b1;
               state_q      <= SEND;
            end

            SEND: begin
               if (dump_ready) begin
                  dump_valid_q <= 1'b0;
                  if (dump_last_q) begin
                     // A halt that already dropped mid-dump leaves done low and
                     // lets DONE fall straight through to IDLE.
                     done_q  <= halted;
                     state_q <= DONE;
                  end else begin
                     idx_q      <= idx_q + 1'b1;
                     rf_rd_en_q <= 1'b1;
                     rf_addr_q  <= idx_q + 1'b1;
                     state_q    <= RD;
                  end
               end
            end

            DONE: begin
               if (!halted) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign rf_rd_en   = rf_rd_en_q;
   assign rf_addr    = rf_addr_q;
   assign dump_valid = dump_valid_q;
   assign dump_data  = dump_data_q;
   assign dump_idx   = dump_idx_q;
   assign dump_last  = dump_last_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Bench for mips32_reg_dump: three instances (8, 1 and 32 registers) share one
// register-file image and control inputs; a monitor logs accepted words and events.
module tb_mips32_reg_dump;
   import mips32_pkg::*;

   localparam int NI = 3;
   localparam int RC [NI] = '{8, 1, 32};

   typedef struct {
      int                    inst;
      logic [REG_ADDR_W-1:0] idx;
      logic [DATA_W-1:0]     data;
      logic                  last;
      int                    cyc;
   } word_t;

   logic clk1       = 1'b0;
   logic rst_n      = 1'b0;
   logic halted     = 1'b0;
   logic trig       = 1'b0;
   logic dump_ready = 1'b1;

   logic [NI-1:0]                 rf_rd_en, dump_valid, dump_last, done;
   logic [NI-1:0][REG_ADDR_W-1:0] rf_addr, dump_idx;
   logic [NI-1:0][DATA_W-1:0]     rf_data, dump_data;
   logic [DATA_W-1:0]             rf_mem [32];

   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;
   word_t got_q[$], rd0_q[$], done_q[$];
   int    stall_viol [NI];
   int    addr_viol  [NI];
   logic [NI-1:0] pv, pr, pdone;
   word_t pw [NI];

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mips32_reg_dump #(.REG_COUNT(RC[g])) u_dut (
         .clk1      (clk1),
         .rst_n     (rst_n),
         .halted    (halted),
         .trig      (trig),
         .rf_rd_en  (rf_rd_en[g]),
         .rf_addr   (rf_addr[g]),
         .rf_data   (rf_data[g]),
         .dump_valid(dump_valid[g]),
         .dump_ready(dump_ready),
         .dump_data (dump_data[g]),
         .dump_idx  (dump_idx[g]),
         .dump_last (dump_last[g]),
         .done      (done[g])
      );
   end

   // Register file read port: data valid the cycle after the strobe.
   always @(posedge clk1)
      for (int g = 0; g < NI; g++)
         if (rf_rd_en[g]) rf_data[g] <= rf_mem[rf_addr[g]];

   always @(negedge clk1) begin
      for (int g = 0; g < NI; g++) begin
         if (!rst_n) begin
            pv[g]    <= 1'b0;
            pdone[g] <= 1'b0;
         end else begin
            if (pv[g] && !pr[g] && (!dump_valid[g] || dump_data[g] !== pw[g].data ||
                dump_idx[g] !== pw[g].idx || dump_last[g] !== pw[g].last))
               stall_viol[g] <= stall_viol[g] + 1;
            if (!rf_rd_en[g] && rf_addr[g] != '0) addr_viol[g] <= addr_viol[g] + 1;
            if (dump_valid[g] && dump_ready)
               got_q.push_back('{g, dump_idx[g], dump_data[g], dump_last[g], cyc});
            if (rf_rd_en[g] && rf_addr[g] == '0) rd0_q.push_back('{g, '0, '0, 1'b0, cyc});
            if (done[g] && !pdone[g]) done_q.push_back('{g, '0, '0, 1'b0, cyc});
            pv[g]    <= dump_valid[g];
            pr[g]    <= dump_ready;
            pdone[g] <= done[g];
            pw[g]    <= '{g, dump_idx[g], dump_data[g], dump_last[g], cyc};
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   function automatic int word_count(input int base, input int g);
      int n = 0;
      for (int i = base; i < got_q.size(); i++) if (got_q[i].inst == g) n++;
      return n;
   endfunction

   function automatic word_t word_at(input int base, input int g, input int k);
      word_t w = '{-1, '0, '0, 1'b0, -1};
      int    n = 0;
      for (int i = base; i < got_q.size(); i++)
         if (got_q[i].inst == g) begin
            if (n == k) return got_q[i];
            n++;
         end
      return w;
   endfunction

   // which: 0 = first-read events, 1 = done-rise events
   function automatic int ev_count(input int which, input int base, input int g);
      int n = 0;
      if (which == 0) begin
         for (int i = base; i < rd0_q.size(); i++) if (rd0_q[i].inst == g) n++;
      end else begin
         for (int i = base; i < done_q.size(); i++) if (done_q[i].inst == g) n++;
      end
      return n;
   endfunction

   function automatic int ev_first(input int which, input int base, input int g);
      if (which == 0) begin
         for (int i = base; i < rd0_q.size(); i++) if (rd0_q[i].inst == g) return rd0_q[i].cyc;
      end else begin
         for (int i = base; i < done_q.size(); i++) if (done_q[i].inst == g) return done_q[i].cyc;
      end
      return -1;
   endfunction

   function automatic bit dump_complete(input int base);
      for (int g = 0; g < NI; g++) if (word_count(base, g) < RC[g]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_dump(input int base, input bit rnd);
      int n = 0;
      while (!dump_complete(base) && n < 1000) begin
         if (rnd) dump_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      dump_ready = 1'b1;
      repeat (2) tick();
   endtask

   task automatic wait_word(input string tag, input int g, input int idx);
      bit found = 1'b0;
      for (int n = 0; n < 400 && !found; n++) begin
         if (dump_valid[g] && dump_idx[g] == REG_ADDR_W'(idx)) found = 1'b1;
         else tick();
      end
      check({tag, "_reached"}, 64'(found), 64'(1));
   endtask

   // Expected stream: every register 0..N-1 exactly once, in order, last flag on N-1.
   task automatic verify_dump(input string tag, input int base);
      for (int g = 0; g < NI; g++) begin
         int n = word_count(base, g);
         check($sformatf("%s_g%0d_count", tag, g), 64'(n), 64'(RC[g]));
         for (int i = 0; i < n && i < RC[g]; i++) begin
            word_t w = word_at(base, g, i);
            check($sformatf("%s_g%0d_w%0d_idx", tag, g, i), 64'(w.idx), 64'(i));
            check($sformatf("%s_g%0d_w%0d_data", tag, g, i), 64'(w.data), 64'(rf_mem[i]));
            check($sformatf("%s_g%0d_w%0d_last", tag, g, i), 64'(w.last), 64'(i == RC[g] - 1));
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int g = 0; g < NI; g++) begin
         check($sformatf("%s_g%0d_ctl", tag, g),
               64'({rf_rd_en[g], dump_valid[g], dump_last[g], done[g]}), 64'(0));
         check($sformatf("%s_g%0d_addr_idx", tag, g), 64'({rf_addr[g], dump_idx[g]}), 64'(0));
         check($sformatf("%s_g%0d_data", tag, g), 64'(dump_data[g]), 64'(0));
      end
   endtask

   initial begin
      int base, rb, db, t0, r;

      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;

      // Reset state
      repeat (3) tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      repeat (3) tick();

      // Arithmetic program results: ADDI/ADDI/ADD/SUBI/SUB/MUL/MULI
      rf_mem[0] = 0;
      rf_mem[1] = rf_mem[0] + 20;
      rf_mem[2] = rf_mem[1] + 10;
      rf_mem[3] = rf_mem[1] + rf_mem[2];
      rf_mem[4] = rf_mem[3] - 15;
      rf_mem[5] = rf_mem[4] - rf_mem[1];
      rf_mem[6] = rf_mem[4] * rf_mem[5];
      rf_mem[7] = rf_mem[3] * 30;
      base = got_q.size(); rb = rd0_q.size(); db = done_q.size();
      halted = 1'b1;
      t0 = cyc;
      wait_dump(base, 1'b0);
      verify_dump("arith", base);
      r = ev_first(0, rb, 0);
      check("arith_rd_after_edge", 64'(r), 64'(t0 + 1));
      check("arith_first_valid", 64'(word_at(base, 0, 0).cyc), 64'(r + 2));
      check("arith_done_g0", 64'(ev_first(1, db, 0)), 64'(r + 24));
      check("arith_done_g1", 64'(ev_first(1, db, 1)), 64'(r + 3));
      check("arith_done_g2", 64'(ev_first(1, db, 2)), 64'(r + 96));
      check("arith_done_held", 64'(done), 64'(3'b111));

      // Backpressure on idx 3 for five cycles
      halted = 1'b0;
      repeat (3) tick();
      check("bp_done_cleared", 64'(done), 64'(0));
      base = got_q.size();
      halted = 1'b1;
      wait_word("bp", 0, 3);
      dump_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold%0d", k),
               64'({dump_valid[0], dump_idx[0], dump_data[0]}), 64'({1'b1, 5'd3, rf_mem[3]}));
         tick();
      end
      dump_ready = 1'b1;
      wait_dump(base, 1'b0);
      verify_dump("bp", base);

      // Halt drops during word 2: dump completes, done never rises on the 8-word instance
      halted = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      base = got_q.size(); rb = rd0_q.size(); db = done_q.size();
      halted = 1'b1;
      wait_word("hfall", 0, 2);
      halted = 1'b0;
      wait_dump(base, 1'b0);
      verify_dump("hfall", base);
      check("hfall_no_done", 64'(ev_count(1, db, 0)), 64'(0));
      check("hfall_one_start", 64'(ev_count(0, rb, 0)), 64'(1));
      check("hfall_idle", 64'({done, dump_valid}), 64'(0));

      // Reset during SEND of idx 4, then trig restart
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      base = got_q.size();
      halted = 1'b1;
      wait_word("rst3", 0, 3);
      tick();
      wait_word("rst4", 0, 4);
      dump_ready = 1'b0;
      @(negedge clk1);
      #1 rst_n = 1'b0;
      #1 check_idle_outputs("rst_async");
      repeat (2) tick();
      rst_n = 1'b0;
      rst_n = 1'b1;
      dump_ready = 1'b1;
      base = got_q.size(); rb = rd0_q.size();
      repeat (10) tick();
      check("rst_no_restart_words", 64'(got_q.size() - base), 64'(0));
      check("rst_no_restart_reads", 64'(rd0_q.size() - rb), 64'(0));
      check_idle_outputs("rst_after");
      trig = 1'b1;
      tick();
      trig = 1'b0;
      wait_word("trig_send", 0, 5);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      wait_dump(base, 1'b0);
      verify_dump("trig", base);
      for (int g = 0; g < NI; g++)
         check($sformatf("trig_g%0d_one_start", g), 64'(ev_count(0, rb, g)), 64'(1));
      trig = 1'b1;
      tick();
      trig = 1'b0;
      repeat (10) tick();
      check("trig_in_done_ignored", 64'(rd0_q.size() - rb), 64'(NI));

      // Randomized data and sink stalls; first pass also pulses trig with the halt edge
      for (int it = 0; it < 4; it++) begin
         halted = 1'b0;
         repeat (3) tick();
         for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
         base = got_q.size(); rb = rd0_q.size();
         halted = 1'b1;
         trig   = (it == 0);
         tick();
         trig = 1'b0;
         wait_dump(base, 1'b1);
         verify_dump($sformatf("rnd%0d", it), base);
         for (int g = 0; g < NI; g++)
            check($sformatf("rnd%0d_g%0d_one_start", it, g), 64'(ev_count(0, rb, g)), 64'(1));
      end

      for (int g = 0; g < NI; g++) begin
         check($sformatf("stall_stable_g%0d", g), 64'(stall_viol[g]), 64'(0));
         check($sformatf("addr_zero_g%0d", g), 64'(addr_viol[g]), 64'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips32_reg_dump.md
# mips32_reg_dump

Post-halt register-file readout engine for the mips32 core. When the core asserts `halted` (HLT retired), the block walks general-purpose registers R0..R(REG_COUNT-1) through a dedicated one-cycle-latency read port. It streams each value out on a valid/ready channel tagged with its register index. It is the hardware reader for the register state a program leaves behind, and sits beside the core on the debug/observation path.

## Interface
- `REG_COUNT`, default 8: number of registers dumped, starting at R0. Legal range 1..32.
- `clk1`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `halted`  in  1  core HALTED flag, level.
- `trig`  in  1  single-cycle re-dump request; honoured only in IDLE while `halted`=1.
- `rf_rd_en`  out  1  register-file read strobe.
- `rf_addr`  out  5  register-file read address.
- `rf_data`  in  32  read data, valid the cycle after `rf_rd_en`.
- `dump_valid`  out  1  output word valid.
- `dump_ready`  in  1  sink accepts the word.
- `dump_data`  out  32  register value.
- `dump_idx`  out  5  register number of `dump_data`.
- `dump_last`  out  1  current word is R(REG_COUNT-1).
- `done`  out  1  dump complete; held until `halted` falls.

## Operation
- Reset values: all outputs 0. State is IDLE. `idx`=0. `halted_q`=0.
- `halted_q` registers `halted` every cycle. The start condition is `halted & ~halted_q` (rising edge), or `trig & halted` while in IDLE.
- States and transitions:
  - IDLE: on start, `idx`←0 and go to RD.
  - RD: `rf_rd_en`=1, `rf_addr`=`idx`; go to CAP.
  - CAP: `dump_data`←`rf_data`, `dump_idx`←`idx`, `dump_last`←(`idx`==REG_COUNT-1); go to SEND.
  - SEND: `dump_valid`=1. On `dump_ready`, either go to DONE (if `dump_last`) or increment `idx` and go to RD.
  - DONE: `done`=1. When `halted`=0, clear `done` and go to IDLE.
- Handshake: while `dump_valid`=1 and `dump_ready`=0, `dump_data`, `dump_idx` and `dump_last` are held stable. `dump_valid` never drops without a transfer.
- `rf_rd_en` is high only in RD. `rf_addr` is 0 in all other states.
- `halted` falling mid-dump is ignored: the dump completes, then DONE falls through to IDLE on the next cycle.
- `trig` outside IDLE, or with `halted`=0, is ignored. A simultaneous edge and `trig` give a single start.
- Reset mid-dump aborts immediately. No partial word is presented after reset releases.
- `dump_data` is unsigned raw 32-bit; no width conversion.

## Timing
- Sample `halted` rise at edge E0. State is RD in the cycle after E0. State is CAP the next cycle. `dump_valid` is first high two cycles after RD.
- Per word: 3 cycles minimum (RD, CAP, SEND with `dump_ready`=1), plus one cycle per stalled SEND cycle.
- Full dump with `dump_ready` tied high: 3·REG_COUNT cycles from the first RD to the DONE entry. `done` rises on the edge that accepts the last word.
- `rf_data` is sampled only on the edge leaving CAP. Its value in other cycles is don't-care.

## Structure
- Shared package `mips32_pkg`:
  - `REG_ADDR_W`=5 and `DATA_W`=32.
  - `typedef enum logic [2:0] {IDLE, RD, CAP, SEND, DONE} regdump_state_t`.
- Single module with no sub-modules. The edge detector and index counter are inline.
- The core exposes the read port (`rf_rd_en`/`rf_addr` → registered `rf_data`) in addition to its pipeline ports.

## Test plan
- Arithmetic program, REG_COUNT=8: run ADDI/ADD/SUBI/SUB/MULI/MUL then HLT, with `dump_ready`=1. Required stream is (idx,data) = (0,0)(1,20)(2,30)(3,50)(4,35)(5,15)(6,525)(7,1500). `dump_last` is high only on idx 7. `done` is set 24 cycles after the first RD.
- Backpressure: hold `dump_ready` low for 5 cycles on idx 3. `dump_valid`/`dump_data`=50/`dump_idx`=3 stay stable for those cycles, and no word is lost or duplicated.
- Re-trigger: `trig` pulse in IDLE with `halted`=1 produces a second identical 8-word dump. `trig` pulses while in SEND are ignored, giving one dump only.
- `halted` falls at word 2: all 8 words are still emitted. The state goes DONE→IDLE on the next cycle and `done` stays low.
- Reset mid-dump: assert `rst_n`=0 during SEND of idx 4. All outputs go to 0 asynchronously. After release with `halted` still 1, no dump starts (no edge), and a `trig` pulse restarts the dump from idx 0.
- REG_COUNT=1 and REG_COUNT=32: dumps of exactly 1 and 32 words. `dump_idx` wraps nowhere, and the last index is 0 and 31 respectively.
